// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: ALU op codes, forwarding source
// select and the control word that a squashed slot loads.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_NOR  = 4'd3,
    ALU_SLLV = 4'd4,
    ALU_SRLV = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SRL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic    valid;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    alu_op_e alu_ctl;
  } ex_ctl_t;

  localparam ex_ctl_t BUBBLE_CTL = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_ctl:   ALU_AND
  };

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode, the later pipeline stages and the ID/EX operand stage.
// id_valid qualifies the decode slot; there is no ready: stall is the only backpressure.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [3:0]        id_alu_ctl;
  logic              id_a_sel;
  logic              id_b_sel;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              flush;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_result;

  logic              stall;
  logic              ex_valid;
  logic [3:0]        ex_alu_ctl;
  logic [DATA_W-1:0] ex_alu_a;
  logic [DATA_W-1:0] ex_alu_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  pipe_pkg::fwd_sel_e fwd_rs_src;
  pipe_pkg::fwd_sel_e fwd_rt_src;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_val, id_rt_val, id_imm, id_shamt,
           id_alu_ctl, id_a_sel, id_b_sel, id_uses_rs, id_uses_rt, id_reg_write,
           id_mem_read, id_mem_write, flush, mem_reg_write, mem_rd, mem_result,
           wb_reg_write, wb_rd, wb_result,
    input  stall, ex_valid, ex_alu_ctl, ex_alu_a, ex_alu_b, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, fwd_rs_src, fwd_rt_src
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_val, id_rt_val, id_imm, id_shamt,
           id_alu_ctl, id_a_sel, id_b_sel, id_uses_rs, id_uses_rt, id_reg_write,
           id_mem_read, id_mem_write, flush, mem_reg_write, mem_rd, mem_result,
           wb_reg_write, wb_rd, wb_result,
    output stall, ex_valid, ex_alu_ctl, ex_alu_a, ex_alu_b, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, fwd_rs_src, fwd_rt_src
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// One forwarding mux: picks EX/MEM, then MEM/WB, then the registered file value.
// Register 0 is hardwired, so an index of 0 never matches a producer.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] value,
  output fwd_sel_e          src
);
  logic nonzero;
  assign nonzero = (idx != '0);

  always_comb begin
    src   = FWD_REG;
    value = reg_val;
    if (nonzero && mem_reg_write && (mem_rd == idx)) begin
      src   = FWD_MEM;
      value = mem_result;
    end else if (nonzero && wb_reg_write && (wb_rd == idx)) begin
      src   = FWD_WB;
      value = wb_result;
    end
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX operand selection: load-use stall, squash to
// bubble, and EX/MEM / MEM/WB forwarding onto the ALU A/B operands.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic                 clk,
  input logic                 reset_n,
  id_ex_operand_stage_if.slave bus
);
  ex_ctl_t           ctl_q, ctl_d;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q, rs_d, rt_d, rd_d;
  logic [DATA_W-1:0] rs_val_q, rt_val_q, imm_q;
  logic [4:0]        shamt_q;
  logic              a_sel_q, b_sel_q;
  logic              load_use;
  logic              bubble;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // A load in EX cannot forward its data until MEM/WB, so a dependent decode must wait.
  assign load_use = ctl_q.valid & ctl_q.mem_read & (rd_q != '0) & bus.id_valid &
                    ((bus.id_uses_rs & (bus.id_rs == rd_q)) |
                     (bus.id_uses_rt & (bus.id_rt == rd_q)));
  assign bus.stall = load_use;
  assign bubble    = bus.flush | load_use;

  always_comb begin
    ctl_d = BUBBLE_CTL;
    rs_d  = '0;
    rt_d  = '0;
    rd_d  = '0;
    if (!bubble) begin
      ctl_d.valid     = bus.id_valid;
      ctl_d.reg_write = bus.id_valid & bus.id_reg_write;
      ctl_d.mem_read  = bus.id_valid & bus.id_mem_read;
      ctl_d.mem_write = bus.id_valid & bus.id_mem_write;
      ctl_d.alu_ctl   = alu_op_e'(bus.id_alu_ctl);
      rs_d            = bus.id_rs;
      rt_d            = bus.id_rt;
      rd_d            = bus.id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q    <= BUBBLE_CTL;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
      a_sel_q  <= 1'b0;
      b_sel_q  <= 1'b0;
    end else begin
      ctl_q    <= ctl_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rs_val_q <= bus.id_rs_val;
      rt_val_q <= bus.id_rt_val;
      imm_q    <= bus.id_imm;
      shamt_q  <= bus.id_shamt;
      a_sel_q  <= bus.id_a_sel;
      b_sel_q  <= bus.id_b_sel;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx(rs_q), .reg_val(rs_val_q),
    .mem_reg_write(bus.mem_reg_write), .mem_rd(bus.mem_rd), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_result(bus.wb_result),
    .value(fwd_rs), .src(bus.fwd_rs_src)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx(rt_q), .reg_val(rt_val_q),
    .mem_reg_write(bus.mem_reg_write), .mem_rd(bus.mem_rd), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_result(bus.wb_result),
    .value(fwd_rt), .src(bus.fwd_rt_src)
  );

  assign bus.ex_valid      = ctl_q.valid;
  assign bus.ex_reg_write  = ctl_q.reg_write;
  assign bus.ex_mem_read   = ctl_q.mem_read;
  assign bus.ex_mem_write  = ctl_q.mem_write;
  assign bus.ex_alu_ctl    = ctl_q.alu_ctl;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_alu_a      = a_sel_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
  assign bus.ex_alu_b      = b_sel_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed hazard/forwarding scenarios plus a
// random stream, checked against a scoreboard of expected EX-stage outputs.
module tb_id_ex_operand_stage;
  localparam int VW = 109;

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0] shamt;
    logic [3:0] alu;
    logic       a_sel, b_sel, uses_rs, uses_rt, reg_write, mem_read, mem_write;
  } op_t;

  logic clk;
  logic reset_n;
  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] exp_q[$];
  int checks;
  int failures;

  logic        m_valid, m_mem_read;
  logic [4:0]  m_rd;
  logic        f_mrw, f_wrw;
  logic [4:0]  f_mrd, f_wrd;
  logic [31:0] f_mres, f_wres;
  logic        obs_stall, exp_stall;

  function automatic logic [VW-1:0] ex_vec();
    return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
            bus.ex_alu_ctl, bus.ex_rd, bus.ex_alu_a, bus.ex_alu_b, bus.ex_store_data};
  endfunction

  function automatic op_t nop();
    op_t o;
    o = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, rs_val: 32'd0, rt_val: 32'd0,
          imm: 32'd0, shamt: 5'd0, alu: 4'd0, a_sel: 1'b0, b_sel: 1'b0, uses_rs: 1'b0,
          uses_rt: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};
    return o;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0 && f_mrw && f_mrd == idx) return f_mres;
    if (idx != 5'd0 && f_wrw && f_wrd == idx) return f_wres;
    return v;
  endfunction

  task automatic clear_env();
    f_mrw = 0; f_wrw = 0; f_mrd = 0; f_wrd = 0; f_mres = 0; f_wres = 0;
  endtask

  // Drives one decode slot at the negedge, records the stall seen before the
  // capturing edge, pushes the expected EX view, and returns 1ns after the edge.
  task automatic drive(input op_t op, input logic fl);
    logic [31:0] frs, frt, a, b;
    logic        st, v, rw, mr, mw;
    logic [3:0]  alu;
    logic [4:0]  rs_e, rt_e, rd_e;
    @(negedge clk);
    bus.id_valid = op.valid; bus.id_rs = op.rs; bus.id_rt = op.rt; bus.id_rd = op.rd;
    bus.id_rs_val = op.rs_val; bus.id_rt_val = op.rt_val; bus.id_imm = op.imm;
    bus.id_shamt = op.shamt; bus.id_alu_ctl = op.alu; bus.id_a_sel = op.a_sel;
    bus.id_b_sel = op.b_sel; bus.id_uses_rs = op.uses_rs; bus.id_uses_rt = op.uses_rt;
    bus.id_reg_write = op.reg_write; bus.id_mem_read = op.mem_read;
    bus.id_mem_write = op.mem_write; bus.flush = fl;
    bus.mem_reg_write = f_mrw; bus.mem_rd = f_mrd; bus.mem_result = f_mres;
    bus.wb_reg_write = f_wrw; bus.wb_rd = f_wrd; bus.wb_result = f_wres;
    st = m_valid && m_mem_read && (m_rd != 0) && op.valid &&
         ((op.uses_rs && op.rs == m_rd) || (op.uses_rt && op.rt == m_rd));
    #1;
    obs_stall = bus.stall;
    exp_stall = st;
    if (fl || st) begin
      v = 0; rw = 0; mr = 0; mw = 0; alu = 0; rs_e = 0; rt_e = 0; rd_e = 0;
    end else begin
      v = op.valid; rw = op.valid & op.reg_write; mr = op.valid & op.mem_read;
      mw = op.valid & op.mem_write; alu = op.alu; rs_e = op.rs; rt_e = op.rt; rd_e = op.rd;
    end
    frs = fwd(rs_e, op.rs_val);
    frt = fwd(rt_e, op.rt_val);
    a = op.a_sel ? {27'd0, op.shamt} : frs;
    b = op.b_sel ? op.imm : frt;
    exp_q.push_back({v, rw, mr, mw, alu, rd_e, a, b, frt});
    m_valid = v; m_mem_read = mr; m_rd = rd_e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] got;
    reset_n = 1'b0;
    clear_env();
    drive_idle_inputs();
    m_valid = 0; m_mem_read = 0; m_rd = 0;
    #12;
    got = ex_vec();
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL reset_outs got=%h exp=0", got);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive_idle_inputs();
    op_t o;
    o = nop();
    bus.id_valid = o.valid; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rs_val = 0; bus.id_rt_val = 0; bus.id_imm = 0; bus.id_shamt = 0;
    bus.id_alu_ctl = 0; bus.id_a_sel = 0; bus.id_b_sel = 0; bus.id_uses_rs = 0;
    bus.id_uses_rt = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.flush = 0; bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  task automatic test_fwd_mem();
    op_t o;
    logic [VW-1:0] e, got;
    clear_env();
    o = nop();
    o.valid = 1; o.rs = 1; o.rt = 2; o.rd = 3; o.rs_val = 32'h5; o.rt_val = 32'h7;
    o.alu = 4'd2; o.uses_rs = 1; o.uses_rt = 1; o.reg_write = 1;
    drive(o, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL add_ex got=%h exp=%h", got, e); end
    o.rs = 3; o.rt = 1; o.rd = 4; o.rs_val = 32'h99; o.rt_val = 32'h5; o.alu = 4'd6;
    f_mrw = 1; f_mrd = 3; f_mres = 32'h10;
    drive(o, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL sub_ex got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_alu_a !== 32'h10) begin
      failures++; $display("FAIL sub_fwd_a got=%h exp=00000010", bus.ex_alu_a);
    end
    checks++;
    if (bus.ex_alu_b !== 32'h5) begin
      failures++; $display("FAIL sub_b got=%h exp=00000005", bus.ex_alu_b);
    end
  endtask

  task automatic test_priority();
    op_t o;
    logic [VW-1:0] e, got;
    clear_env();
    o = nop();
    o.valid = 1; o.rs = 2; o.rt = 5; o.rd = 7; o.rs_val = 32'h1; o.rt_val = 32'h2;
    o.alu = 4'd1; o.uses_rs = 1; o.uses_rt = 1; o.reg_write = 1;
    f_mrw = 1; f_mrd = 5; f_mres = 32'hA; f_wrw = 1; f_wrd = 5; f_wres = 32'hB;
    drive(o, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL prio_ex got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_alu_b !== 32'hA) begin
      failures++; $display("FAIL prio_mem_wins got=%h exp=0000000a", bus.ex_alu_b);
    end
    f_mrw = 0;
    drive(o, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL wb_only_ex got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_store_data !== 32'hB) begin
      failures++; $display("FAIL wb_store got=%h exp=0000000b", bus.ex_store_data);
    end
  endtask

  task automatic test_load_use();
    op_t ld, use_op;
    logic [VW-1:0] e, got;
    clear_env();
    ld = nop();
    ld.valid = 1; ld.rs = 1; ld.rd = 6; ld.imm = 32'h4; ld.b_sel = 1; ld.alu = 4'd2;
    ld.uses_rs = 1; ld.reg_write = 1; ld.mem_read = 1;
    drive(ld, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL lw_ex got=%h exp=%h", got, e); end
    use_op = nop();
    use_op.valid = 1; use_op.rs = 2; use_op.rt = 6; use_op.rd = 8; use_op.rs_val = 32'h3;
    use_op.rt_val = 32'h0; use_op.alu = 4'd2; use_op.uses_rs = 1; use_op.uses_rt = 1;
    use_op.reg_write = 1;
    drive(use_op, 0);
    checks++;
    if (obs_stall !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", obs_stall);
    end
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL lu_bubble got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      failures++; $display("FAIL lu_bubble_ctl got=%b%b exp=00", bus.ex_valid, bus.ex_reg_write);
    end
    f_wrw = 1; f_wrd = 6; f_wres = 32'h77;
    drive(use_op, 0);
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL lu_release got=%b exp=0", obs_stall);
    end
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL lu_issue got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_alu_b !== 32'h77 || bus.ex_valid !== 1'b1) begin
      failures++; $display("FAIL lu_issue_b got=%h exp=00000077", bus.ex_alu_b);
    end
  endtask

  task automatic test_zero_reg();
    op_t o;
    logic [VW-1:0] e, got;
    clear_env();
    o = nop();
    o.valid = 1; o.rs = 0; o.rt = 4; o.rd = 9; o.rt_val = 32'h12; o.alu = 4'd8;
    o.uses_rs = 1; o.uses_rt = 1; o.reg_write = 1;
    f_mrw = 1; f_mrd = 0; f_mres = 32'hFFFF; f_wrw = 1; f_wrd = 0; f_wres = 32'hEEEE;
    drive(o, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL zero_ex got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_alu_a !== 32'h0) begin
      failures++; $display("FAIL zero_no_fwd got=%h exp=00000000", bus.ex_alu_a);
    end
  endtask

  task automatic test_flush();
    op_t ld, o;
    logic [VW-1:0] e, got;
    clear_env();
    ld = nop();
    ld.valid = 1; ld.rd = 10; ld.alu = 4'd2; ld.reg_write = 1; ld.mem_read = 1;
    drive(ld, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL fl_lw got=%h exp=%h", got, e); end
    o = nop();
    o.valid = 1; o.rs = 10; o.rd = 11; o.alu = 4'd1; o.uses_rs = 1; o.reg_write = 1;
    o.mem_write = 1;
    drive(o, 1);
    checks++;
    if (obs_stall !== 1'b1) begin
      failures++; $display("FAIL fl_stall got=%b exp=1", obs_stall);
    end
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e || bus.ex_valid !== 1'b0 || bus.ex_mem_write !== 1'b0) begin
      failures++; $display("FAIL fl_bubble got=%h exp=%h", got, e);
    end
    o = nop();
    o.valid = 1; o.rs = 1; o.rd = 12; o.rs_val = 32'h100; o.imm = 32'hFFFFFFFC;
    o.b_sel = 1; o.alu = 4'd2; o.uses_rs = 1; o.reg_write = 1;
    drive(o, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL imm_ex got=%h exp=%h", got, e); end
    checks++;
    if (bus.ex_alu_b !== 32'hFFFFFFFC) begin
      failures++; $display("FAIL imm_b got=%h exp=fffffffc", bus.ex_alu_b);
    end
  endtask

  task automatic test_random();
    op_t o;
    logic [VW-1:0] e, got;
    for (int i = 0; i < 40; i++) begin
      o = nop();
      o.valid = ($urandom_range(0, 7) != 0);
      o.rs = 5'($urandom_range(0, 7)); o.rt = 5'($urandom_range(0, 7));
      o.rd = 5'($urandom_range(0, 7));
      o.rs_val = $urandom; o.rt_val = $urandom; o.imm = $urandom;
      o.shamt = 5'($urandom_range(0, 31)); o.alu = 4'($urandom_range(0, 10));
      o.a_sel = ($urandom_range(0, 3) == 0); o.b_sel = ($urandom_range(0, 2) == 0);
      o.uses_rs = 1'($urandom_range(0, 1)); o.uses_rt = 1'($urandom_range(0, 1));
      o.reg_write = 1'($urandom_range(0, 1)); o.mem_read = ($urandom_range(0, 2) == 0);
      o.mem_write = ($urandom_range(0, 4) == 0);
      f_mrw = 1'($urandom_range(0, 1)); f_mrd = 5'($urandom_range(0, 7)); f_mres = $urandom;
      f_wrw = 1'($urandom_range(0, 1)); f_wrd = 5'($urandom_range(0, 7)); f_wres = $urandom;
      drive(o, ($urandom_range(0, 7) == 0));
      checks++;
      if (obs_stall !== exp_stall) begin
        failures++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, obs_stall, exp_stall);
      end
      e = exp_q.pop_front(); got = ex_vec(); checks++;
      if (got !== e) begin failures++; $display("FAIL rnd_ex[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_reset_mid();
    op_t ld, o;
    logic [VW-1:0] e, got;
    clear_env();
    ld = nop();
    ld.valid = 1; ld.rs = 3; ld.rd = 13; ld.rs_val = 32'h55; ld.alu = 4'd2;
    ld.uses_rs = 1; ld.reg_write = 1; ld.mem_read = 1;
    drive(ld, 0);
    e = exp_q.pop_front(); got = ex_vec(); checks++;
    if (got !== e) begin failures++; $display("FAIL mid_lw got=%h exp=%h", got, e); end
    o = nop();
    o.valid = 1; o.rs = 13; o.rd = 14; o.uses_rs = 1; o.reg_write = 1;
    drive(o, 0);
    void'(exp_q.pop_front());
    drive(o, 0);
    void'(exp_q.pop_front());
    #2;
    reset_n = 1'b0;
    #1;
    got = ex_vec(); checks++;
    if (got !== '0) begin failures++; $display("FAIL mid_reset_outs got=%h exp=0", got); end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL mid_reset_stall got=%b exp=0", bus.stall);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_valid = 0; m_mem_read = 0; m_rd = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fwd_mem();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
